// File: rtl/parqueo_sensores.sv
// Sensor front end for the four-spot parking lot: optional synchronizer, per-spot debouncer,
// occupancy outputs and a valid/ready change-event channel. Optional macro: PARQUEO_SYNC_EN.
module parqueo_sensores #(
   parameter int unsigned DEBOUNCE_CYCLES = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] raw_sensor,
   output logic [3:0] occ,
   output logic [2:0] free_count,
   output logic       full,
   output logic       evt_valid,
   input  logic       evt_ready,
   output logic [3:0] evt_occ,
   output logic       evt_overrun,
   input  logic       evt_overrun_clr
);

   localparam int unsigned NUM_SPOTS = 4;
   localparam int unsigned CNT_W     = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [NUM_SPOTS-1:0]            s;
   logic [NUM_SPOTS-1:0][CNT_W-1:0] cnt_q;
   logic [NUM_SPOTS-1:0][CNT_W-1:0] cnt_d;
   logic [NUM_SPOTS-1:0]            occ_d;
   logic                            change_c;
   logic                            xfer_c;

`ifdef PARQUEO_SYNC_EN
   logic [NUM_SPOTS-1:0] sync_q1;
   logic [NUM_SPOTS-1:0] sync_q2;

   // Two-flop synchronizer for the asynchronous sensor inputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q1 <= '0;
         sync_q2 <= '0;
      end else begin
         sync_q1 <= raw_sensor;
         sync_q2 <= sync_q1;
      end
   end

   assign s = sync_q2;
`else
   assign s = raw_sensor;
`endif

   // Per-spot debounce: flip only after DEBOUNCE_CYCLES consecutive disagreeing cycles
   always_comb begin
      occ_d = occ;
      cnt_d = '0;
      for (int i = 0; i < NUM_SPOTS; i++) begin
         if (s[i] != occ[i]) begin
            if (cnt_q[i] == CNT_MAX) begin
               occ_d[i] = s[i];
            end else begin
               cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
         end
      end
   end

   assign change_c = (occ_d != occ);
   assign xfer_c   = evt_valid && evt_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         occ   <= '0;
         cnt_q <= '0;
      end else begin
         occ   <= occ_d;
         cnt_q <= cnt_d;
      end
   end

   // Event channel: a new change always wins over a transfer and refreshes the snapshot
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         evt_valid   <= 1'b0;
         evt_occ     <= '0;
         evt_overrun <= 1'b0;
      end else begin
         if (change_c) begin
            evt_valid <= 1'b1;
            evt_occ   <= occ_d;
         end else if (xfer_c) begin
            evt_valid <= 1'b0;
         end
         if (change_c && evt_valid && !xfer_c) begin
            evt_overrun <= 1'b1;
         end else if (evt_overrun_clr) begin
            evt_overrun <= 1'b0;
         end
      end
   end

   // Free-spot count and full flag follow occ within the same cycle
   always_comb begin
      free_count = 3'(NUM_SPOTS);
      for (int i = 0; i < NUM_SPOTS; i++) begin
         free_count = free_count - 3'(occ[i]);
      end
   end

   assign full = &occ;

endmodule

// File: tb/tb_parqueo_sensores.sv
// Self-checking bench for parqueo_sensores: vector table plus hand-written event-channel sequences,
// with a scoreboard queue of expected event snapshots checked on every transfer.
module tb_parqueo_sensores;

   localparam int unsigned D = 4;
`ifdef PARQUEO_SYNC_EN
   localparam int EDGES_TO_FLIP = D + 2;
`else
   localparam int EDGES_TO_FLIP = D;
`endif
   localparam int HOLD = D + 6;
   localparam int WAIT_MAX = 40;

   logic       clk;
   logic       rst_n;
   logic [3:0] raw_sensor;
   logic [3:0] occ;
   logic [2:0] free_count;
   logic       full;
   logic       evt_valid;
   logic       evt_ready;
   logic [3:0] evt_occ;
   logic       evt_overrun;
   logic       evt_overrun_clr;

   int checks = 0;
   int errors = 0;
   logic [3:0] sb_q[$];
   logic [3:0] mon_exp;

   typedef struct {
      logic [3:0] raw;
      logic [3:0] occ;
      logic [2:0] free;
      logic       full;
   } vec_t;
   vec_t vecs[8];

   parqueo_sensores #(.DEBOUNCE_CYCLES(D)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .raw_sensor      (raw_sensor),
      .occ             (occ),
      .free_count      (free_count),
      .full            (full),
      .evt_valid       (evt_valid),
      .evt_ready       (evt_ready),
      .evt_occ         (evt_occ),
      .evt_overrun     (evt_overrun),
      .evt_overrun_clr (evt_overrun_clr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wait_occ(input logic [3:0] v, output int edges);
      edges = 0;
      while (occ !== v && edges < WAIT_MAX) begin
         tick(1);
         edges++;
      end
      if (occ !== v) begin
         checks++;
         errors++;
         $display("FAIL wait_occ timeout: occ=%b, expected %b", occ, v);
      end
   endtask

   // Scoreboard: every transfer must carry the oldest expected snapshot
   always @(negedge clk) begin
      if (rst_n && evt_valid && evt_ready) begin
         if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL evt_unexpected: got evt_occ=%b, expected no event", evt_occ);
         end else begin
            mon_exp = sb_q.pop_front();
            chk("evt_transfer", 8'(evt_occ), 8'(mon_exp));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected finish before 200000");
      $fatal(1, "watchdog");
   end

   initial begin
      int e;
      vecs[0] = '{4'b1010, 4'b1010, 3'd2, 1'b0};
      vecs[1] = '{4'b1111, 4'b1111, 3'd0, 1'b1};
      vecs[2] = '{4'b0111, 4'b0111, 3'd1, 1'b0};
      vecs[3] = '{4'b1111, 4'b1111, 3'd0, 1'b1};
      vecs[4] = '{4'b0000, 4'b0000, 3'd4, 1'b0};
      vecs[5] = '{4'b0110, 4'b0110, 3'd2, 1'b0};
      vecs[6] = '{4'b1000, 4'b1000, 3'd3, 1'b0};
      vecs[7] = '{4'b0000, 4'b0000, 3'd4, 1'b0};

      rst_n = 1'b0;
      raw_sensor = 4'b0000;
      evt_ready = 1'b0;
      evt_overrun_clr = 1'b0;
      tick(3);
      chk("rst_occ", 8'(occ), 8'h0);
      chk("rst_free", 8'(free_count), 8'd4);
      chk("rst_full", 8'(full), 8'h0);
      chk("rst_evt_valid", 8'(evt_valid), 8'h0);
      chk("rst_evt_occ", 8'(evt_occ), 8'h0);
      chk("rst_overrun", 8'(evt_overrun), 8'h0);
      rst_n = 1'b1;
      tick(2);

      // Glitch of D-1 cycles must be rejected
      raw_sensor = 4'b0100;
      tick(D - 1);
      raw_sensor = 4'b0000;
      for (int i = 0; i < 10; i++) begin
         tick(1);
         chk("glitch_occ", 8'(occ), 8'h0);
         chk("glitch_evt_valid", 8'(evt_valid), 8'h0);
      end

      // Held change: exact latency, derived outputs, pending event
      raw_sensor = 4'b0100;
      sb_q.push_back(4'b0100);
      wait_occ(4'b0100, e);
      chk("latency_edges", 8'(e), 8'(EDGES_TO_FLIP));
      chk("hold_free", 8'(free_count), 8'd3);
      chk("hold_full", 8'(full), 8'h0);
      chk("hold_evt_valid", 8'(evt_valid), 8'h1);
      chk("hold_evt_occ", 8'(evt_occ), 8'b0100);
      evt_ready = 1'b1;
      tick(1);
      evt_ready = 1'b0;
      chk("xfer_evt_valid", 8'(evt_valid), 8'h0);

      raw_sensor = 4'b0000;
      sb_q.push_back(4'b0000);
      evt_ready = 1'b1;
      wait_occ(4'b0000, e);
      tick(2);
      evt_ready = 1'b0;

      // Two spots flipping together form one change (no overrun under backpressure)
      raw_sensor = 4'b1001;
      sb_q.push_back(4'b1001);
      wait_occ(4'b1001, e);
      tick(2);
      chk("simul_free", 8'(free_count), 8'd2);
      chk("simul_evt_valid", 8'(evt_valid), 8'h1);
      chk("simul_evt_occ", 8'(evt_occ), 8'b1001);
      chk("simul_overrun", 8'(evt_overrun), 8'h0);
      evt_ready = 1'b1;
      tick(1);

      for (int i = 0; i < 8; i++) begin
         raw_sensor = vecs[i].raw;
         sb_q.push_back(vecs[i].occ);
         tick(HOLD);
         chk("vec_occ", 8'(occ), 8'(vecs[i].occ));
         chk("vec_free", 8'(free_count), 8'(vecs[i].free));
         chk("vec_full", 8'(full), 8'(vecs[i].full));
         chk("vec_evt_valid", 8'(evt_valid), 8'h0);
      end

      // Backpressure merge and overrun
      evt_ready = 1'b0;
      raw_sensor = 4'b0001;
      sb_q.push_back(4'b0001);
      wait_occ(4'b0001, e);
      raw_sensor = 4'b0011;
      wait_occ(4'b0011, e);
      void'(sb_q.pop_back());
      sb_q.push_back(4'b0011);
      chk("merge_evt_valid", 8'(evt_valid), 8'h1);
      chk("merge_evt_occ", 8'(evt_occ), 8'b0011);
      chk("merge_overrun", 8'(evt_overrun), 8'h1);
      evt_ready = 1'b1;
      tick(1);
      evt_ready = 1'b0;
      chk("merge_xfer_valid", 8'(evt_valid), 8'h0);
      chk("merge_overrun_sticky", 8'(evt_overrun), 8'h1);
      evt_overrun_clr = 1'b1;
      tick(1);
      evt_overrun_clr = 1'b0;
      chk("overrun_clr", 8'(evt_overrun), 8'h0);

      // Change on the same edge as a transfer
      evt_ready = 1'b1;
      raw_sensor = 4'b0001;
      sb_q.push_back(4'b0001);
      wait_occ(4'b0001, e);
      tick(2);
      raw_sensor = 4'b0011;
      sb_q.push_back(4'b0011);
      tick(1);
      raw_sensor = 4'b0111;
      sb_q.push_back(4'b0111);
      wait_occ(4'b0011, e);
      tick(1);
      chk("xchg_occ", 8'(occ), 8'b0111);
      chk("xchg_evt_valid", 8'(evt_valid), 8'h1);
      chk("xchg_evt_occ", 8'(evt_occ), 8'b0111);
      chk("xchg_overrun", 8'(evt_overrun), 8'h0);
      tick(2);

      // Mid-run reset with all sensors active
      raw_sensor = 4'b1111;
      sb_q.push_back(4'b1111);
      wait_occ(4'b1111, e);
      chk("pre_rst_full", 8'(full), 8'h1);
      tick(1);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_occ", 8'(occ), 8'h0);
      chk("mid_rst_free", 8'(free_count), 8'd4);
      chk("mid_rst_full", 8'(full), 8'h0);
      chk("mid_rst_evt_valid", 8'(evt_valid), 8'h0);
      sb_q.delete();
      tick(2);
      rst_n = 1'b1;
      sb_q.push_back(4'b1111);
      wait_occ(4'b1111, e);
      chk("rst_exit_edges", 8'(e), 8'(EDGES_TO_FLIP));
      chk("rst_exit_full", 8'(full), 8'h1);
      chk("rst_exit_evt_valid", 8'(evt_valid), 8'h1);
      chk("rst_exit_evt_occ", 8'(evt_occ), 8'b1111);
      tick(3);
      chk("sb_drained", 8'(sb_q.size()), 8'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
